lora_uart_rx: RTL and testbench

LORA_UART_RX -- requirements
Module: lora_uart_rx

---
 rtl/lora_uart_rx.sv | 69 ++++++
 tb/tb_lora_uart_rx.sv | 116 +++++++++++
 2 files changed

// File: rtl/lora_uart_rx.sv
// lora_uart_rx: 8N1 serial receiver for a LoRa module with start-glitch rejection and framing-error pulse.
module lora_uart_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data_rx,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       nedge,
  output logic       frame_err
);
  localparam int BIT_CNT = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam logic [15:0] BIT_END  = 16'(BIT_CNT - 1);
  localparam logic [15:0] HALF_END = 16'(HALF - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state, state_nx;
  logic        rx_s1, rx_s2, rx_dly;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        half_hit, bit_hit, data_tick, stop_tick;
  assign nedge     = rx_dly & ~rx_s2;
  assign rx_busy   = state != IDLE;
  assign half_hit  = cnt == HALF_END;
  assign bit_hit   = cnt == BIT_END;
  assign data_tick = state == DATA && bit_hit;
  assign stop_tick = state == STOP && bit_hit;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = nedge ? START : IDLE;
      START: state_nx = !half_hit ? START : (rx_s2 ? IDLE : DATA);
      DATA:  state_nx = data_tick && bit_idx == 3'd7 ? STOP : DATA;
      STOP:  state_nx = bit_hit ? IDLE : STOP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_dly    <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data_rx   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= rxd;
      rx_s2     <= rx_s1;
      rx_dly    <= rx_s2;
      state     <= state_nx;
      // Counter also wraps at each data-bit boundary so every bit gets a full period
      cnt       <= (state_nx != state || state == IDLE || data_tick) ? '0 : cnt + 16'd1;
      rx_valid  <= stop_tick && rx_s2;
      frame_err <= stop_tick && !rx_s2;
      if (data_tick) begin
        shift   <= {rx_s2, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (stop_tick && rx_s2) data_rx <= shift;
    end
  end
endmodule

// File: tb/tb_lora_uart_rx.sv
// tb_lora_uart_rx: scoreboard bench driving 8N1 frames, glitches and mid-frame reset into lora_uart_rx.
module tb_lora_uart_rx;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 62_500;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int HALF   = BIT / 2;
  localparam int LAT    = HALF + 9 * BIT + 1;
  logic       clk = 1'b0, rst_n = 1'b0, rxd = 1'b1;
  logic [7:0] data_rx;
  logic       rx_valid, rx_busy, nedge, frame_err;
  int         checks = 0, errors = 0;
  int         cyc = 0, t0 = 0, nedge_cnt = 0, busy_cnt = 0;
  logic [8:0] sb[$];
  logic [7:0] last_good = 8'h00;
  lora_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .data_rx(data_rx), .rx_valid(rx_valid),
    .rx_busy(rx_busy), .nedge(nedge), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT) @(posedge clk);
  endtask
  task automatic send_byte(input logic [7:0] d, input logic stop);
    sb.push_back(stop ? {1'b0, d} : {1'b1, last_good});
    if (stop) last_good = d;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    if (!stop) drive_bit(1'b1);
  endtask
  always @(negedge clk) begin
    logic [8:0] e;
    cyc++;
    if (rst_n) begin
      if (nedge) nedge_cnt++;
      if (nedge && !rx_busy) t0 = cyc;
      if (rx_busy) busy_cnt++;
      if (rx_valid && frame_err) chk("both_pulses", 1, 0);
      if (rx_valid || frame_err) begin
        if (sb.size() == 0) chk("unexpected_pulse", {frame_err, data_rx}, 0);
        else begin
          e = sb.pop_front();
          chk("pulse_kind", frame_err, e[8]);
          chk("data_rx", data_rx, e[7:0]);
          chk("latency_ok", 32'((cyc - t0) >= LAT - 1 && (cyc - t0) <= LAT + 1), 1);
        end
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_rx", data_rx, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_rx_busy", rx_busy, 0);
    chk("rst_nedge", nedge, 0);
    rst_n = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    send_byte(8'h02, 1'b1);
    repeat (2 * BIT) @(posedge clk);
    chk("sb_after_02", sb.size(), 0);
    nedge_cnt = 0;
    busy_cnt  = 0;
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    rxd = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    chk("glitch_nedges", nedge_cnt, 1);
    chk("glitch_busy_ok", 32'(busy_cnt >= HALF - 1 && busy_cnt <= HALF + 1), 1);
    chk("glitch_idle", rx_busy, 0);
    chk("glitch_hold", data_rx, 8'h02);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    repeat (2 * BIT) @(posedge clk);
    chk("b2b_drained", sb.size(), 0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h03, 1'b0);
    repeat (2 * BIT) @(posedge clk);
    chk("ferr_hold", data_rx, 8'h01);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    repeat (2 * BIT) @(posedge clk);
    chk("rand_hold", data_rx, last_good);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    rxd = 1'b0;
    repeat (HALF) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_data_rx", data_rx, 8'h00);
    chk("midrst_busy", rx_busy, 0);
    chk("midrst_nedge", nedge, 0);
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    rxd = 1'b1;
    rst_n = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    chk("postrst_idle", rx_busy, 0);
    chk("postrst_data", data_rx, 8'h00);
    send_byte(8'h02, 1'b1);
    repeat (3 * BIT) @(posedge clk);
    chk("final_data", data_rx, 8'h02);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
